alu181_seq: RTL and testbench

- Multi-cycle, width-generalised successor to the 4-bit 74LS181 ALU.
- Runs the full 181 function set (16 logic ops plus 16 arithmetic ops) on WIDTH-bit operands, one SLICE_W-bit slice per clock, LSB slice first, with the carry held in a register between slices.
- Operands enter and results leave on valid/ready handshakes, so it drops into the datapath wherever a cascade of 181s was used.

---
 rtl/alu181_seq.sv | 107 ++++++++++
 tb/tb_alu181_seq.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu181_seq.sv
// Sequential, width-generalised 74LS181: one SLICE_W-bit slice per clock, LSB first,
// with the ripple carry held in a register between slices.
module alu181_seq #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout_n,
  output logic             aeqb
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if (WIDTH <= 0 || SLICE_W <= 0 || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("alu181_seq: WIDTH must be a positive multiple of SLICE_W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [3:0]         s_q;
  logic               m_q, cn_n_q, carry_q, cout_n_q;
  logic [IDX_W-1:0]   idx_q;

  logic [SLICE_W-1:0] a_sl, b_sl, op1, op2, f_sl;
  logic               c_in, c_out;
  logic               accept, last_slice;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign f         = result_q;
  assign cout_n    = cout_n_q;
  assign aeqb      = out_valid & (&result_q);

  assign accept     = in_valid & in_ready;
  assign last_slice = (idx_q == LAST_IDX);

  // One 181 slice; logic mode suppresses the carry chain entirely.
  always_comb begin
    a_sl = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    b_sl = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
    op1  = a_sl | (b_sl & {SLICE_W{s_q[0]}}) | (~b_sl & {SLICE_W{s_q[1]}});
    op2  = (a_sl & b_sl & {SLICE_W{s_q[3]}}) | (a_sl & ~b_sl & {SLICE_W{s_q[2]}});
    c_in = m_q ? 1'b0 : ((idx_q == '0) ? ~cn_n_q : carry_q);
    if (m_q) begin
      {c_out, f_sl} = {1'b0, ~(op1 ^ op2)};
    end else begin
      {c_out, f_sl} = {1'b0, op1} + {1'b0, op2} + {{SLICE_W{1'b0}}, c_in};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cn_n_q   <= 1'b1;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_n_q <= 1'b1;
      idx_q    <= '0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      s_q    <= s;
      m_q    <= m;
      cn_n_q <= cn_n;
      idx_q  <= '0;
    end else if (state_q == RUN) begin
      result_q[int'(idx_q)*SLICE_W +: SLICE_W] <= f_sl;
      carry_q <= c_out;
      idx_q   <= idx_q + 1'b1;
      if (last_slice) cout_n_q <= ~c_out;
    end
  end

endmodule

// File: tb/tb_alu181_seq.sv
// Randomised and directed bench for alu181_seq, checked against a full-width
// arithmetic model of the 181 function set.
module tb_alu181_seq;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int NS = W / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    s;
  logic          m;
  logic          cn_n;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          cout_n;
  logic          aeqb;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu181_seq #(.WIDTH(W), .SLICE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .cn_n(cn_n),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout_n(cout_n), .aeqb(aeqb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word model: a cascade of 181s with ripple carry is a single wide add.
  function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic [3:0] rs, input logic rm,
                                           input logic rcn_n);
    logic [W-1:0] op1, op2, res;
    logic [W:0]   sum;
    op1 = ra | (rb & {W{rs[0]}}) | (~rb & {W{rs[1]}});
    op2 = (ra & rb & {W{rs[3]}}) | (ra & ~rb & {W{rs[2]}});
    if (rm) begin
      res = ~(op1 ^ op2);
      return {1'b1, res};
    end
    sum = W'(0) + {1'b0, op1} + {1'b0, op2} + (rcn_n ? 0 : 1);
    return {~sum[W], sum[W-1:0]};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                        input logic tm, input logic tcn, input int hold, input logic early);
    logic [W:0]   exp;
    logic [W-1:0] f_held;
    logic         c_held, e_held;
    int           lat;
    int           waitc;
    exp = ref_model(ta, tb_, ts, tm, tcn);
    @(negedge clk);
    a = ta; b = tb_; s = ts; m = tm; cn_n = tcn; in_valid = 1'b1; out_ready = 1'b0;
    waitc = 0;
    while (!in_ready && waitc < 50) begin @(negedge clk); waitc++; end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); cn_n = 1'($urandom);
    out_ready = early;
    check("run_no_valid", {30'd0, out_valid, aeqb}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    out_ready = 1'b0;
    check("latency", lat, NS);
    check("f", {16'd0, f}, {16'd0, exp[W-1:0]});
    check("cout_n", {31'd0, cout_n}, {31'd0, exp[W]});
    check("aeqb", {31'd0, aeqb}, {31'd0, &exp[W-1:0]});
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    f_held = f; c_held = cout_n; e_held = aeqb;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_stable", {14'd0, out_valid, in_ready, f, c_held, e_held},
            {14'd0, 1'b1, 1'b0, f_held, cout_n, aeqb});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cn_n = 1'b1;
    #12;
    check("reset_outs", {12'd0, in_ready, out_valid, cout_n, aeqb, f}, {12'd0, 4'b1010, 16'h0000});
    @(negedge clk); rst = 1'b0;

    run_op(16'h1234, 16'h0F0F, 4'd9, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'hFFFF, 16'h0000, 4'd9, 1'b0, 1'b0, 0, 1'b1);
    run_op(16'h0005, 16'h0005, 4'd6, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'h0005, 16'h0005, 4'd6, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'hA5A5, 16'h3C3C, 4'd0, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h1357, 16'h2468, 4'd3, 1'b0, 1'b1, 0, 1'b0);
    run_op(16'hBEEF, 16'h1234, 4'd9, 1'b0, 1'b1, 5, 1'b0);

    // Abort mid-RUN, then confirm the next op starts from a clean carry.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; s = 4'd9; m = 1'b0; cn_n = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_outs", {12'd0, in_ready, out_valid, cout_n, aeqb, f}, {12'd0, 4'b1010, 16'h0000});
    @(negedge clk); rst = 1'b0;
    run_op(16'h0001, 16'h0001, 4'd9, 1'b0, 1'b1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end
    // Operands chosen so arithmetic S=6 with cn_n=1 yields all ones.
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      run_op(v, v, 4'd6, 1'b0, 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
